// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the registered OP-IMM control bundle
// used by the per-format decoders.
package rv32i_pkg;

  localparam int XLEN_RV32 = 32;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef struct packed {
    logic                 sub_sra;
    logic [2:0]           alu_funct3;
    logic [XLEN_RV32-1:0] imm;
    logic [4:0]           shamt;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic                 reg_we;
    logic                 valid;
  } opimm_dec_t;

  // Immediate shifts reuse imm[11:5] as funct7; only the base/alt patterns are legal.
  function automatic logic opimm_shift_legal(input logic [2:0] funct3,
                                             input logic [6:0] funct7);
    case (funct3)
      F3_SLL:     return (funct7 == 7'b0000000);
      F3_SRL_SRA: return (funct7 == 7'b0000000) || (funct7 == FUNCT7_ALT);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rv_field_extract.sv
// Combinational field slicer shared by the RV32I format decoders.
module rv_field_extract (
  input  logic [31:0] insn,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] imm_i
);

  assign opcode = insn[6:0];
  assign rd     = insn[11:7];
  assign funct3 = insn[14:12];
  assign rs1    = insn[19:15];
  assign funct7 = insn[31:25];
  assign imm_i  = insn[31:20];

endmodule

// File: rtl/decoder_i_insn_alu.sv
// RV32I OP-IMM decoder: slices the instruction word and registers ALU control
// fields (sub_sra selects SRA) with one cycle of latency.
module decoder_i_insn_alu
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     insn,
  output logic            sub_sra,
  output logic [2:0]      alu_funct3,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      shamt,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic            reg_we,
  output logic            valid
);

  logic [6:0]  f_opcode;
  logic [4:0]  f_rd;
  logic [4:0]  f_rs1;
  logic [2:0]  f_funct3;
  logic [6:0]  f_funct7;
  logic [11:0] f_imm_i;

  opimm_dec_t dec_d, dec_q;

  rv_field_extract u_fields (
    .insn   (insn),
    .opcode (f_opcode),
    .rd     (f_rd),
    .rs1    (f_rs1),
    .funct3 (f_funct3),
    .funct7 (f_funct7),
    .imm_i  (f_imm_i)
  );

  always_comb begin
    dec_d            = '0;
    // Raw fields pass through even for illegal encodings; only the qualifiers gate.
    dec_d.alu_funct3 = f_funct3;
    dec_d.imm        = {{(XLEN_RV32-12){f_imm_i[11]}}, f_imm_i};
    dec_d.shamt      = f_imm_i[4:0];
    dec_d.rd         = f_rd;
    dec_d.rs1        = f_rs1;
    dec_d.valid      = (f_opcode == OPCODE_OP_IMM) && opimm_shift_legal(f_funct3, f_funct7);
    // No SUBI exists, so insn[30] only matters for the right-shift funct3.
    dec_d.sub_sra    = dec_d.valid && (f_funct3 == F3_SRL_SRA) && f_funct7[5];
    dec_d.reg_we     = dec_d.valid && (f_rd != 5'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dec_q <= '0;
    else          dec_q <= dec_d;
  end

  assign sub_sra    = dec_q.sub_sra;
  assign alu_funct3 = dec_q.alu_funct3;
  assign imm        = dec_q.imm;
  assign shamt      = dec_q.shamt;
  assign rd         = dec_q.rd;
  assign rs1        = dec_q.rs1;
  assign reg_we     = dec_q.reg_we;
  assign valid      = dec_q.valid;

endmodule

// File: tb/tb_decoder_i_insn_alu.sv
// Scoreboard bench for decoder_i_insn_alu: expected decodes are queued when an
// instruction is driven and compared one cycle later.
`timescale 1ns/1ps
module tb_decoder_i_insn_alu;

  typedef struct packed {
    logic        sub_sra;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        reg_we;
    logic        valid;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] insn;
  logic        sub_sra;
  logic [2:0]  alu_funct3;
  logic [31:0] imm;
  logic [4:0]  shamt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic        reg_we;
  logic        valid;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t sb_q[$];

  decoder_i_insn_alu #(.XLEN(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .insn       (insn),
    .sub_sra    (sub_sra),
    .alu_funct3 (alu_funct3),
    .imm        (imm),
    .shamt      (shamt),
    .rd         (rd),
    .rs1        (rs1),
    .reg_we     (reg_we),
    .valid      (valid)
  );

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic legal;
    case (w[14:12])
      3'b001:  legal = (w[31:25] == 7'b0000000);
      3'b101:  legal = (w[31:25] == 7'b0000000) || (w[31:25] == 7'b0100000);
      default: legal = 1'b1;
    endcase
    e.valid   = (w[6:0] == 7'b0010011) && legal;
    e.sub_sra = e.valid && (w[14:12] == 3'b101) && w[30];
    e.reg_we  = e.valid && (w[11:7] != 5'd0);
    e.f3      = w[14:12];
    e.imm     = {{20{w[31]}}, w[31:20]};
    e.shamt   = w[24:20];
    e.rd      = w[11:7];
    e.rs1     = w[19:15];
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".sub_sra"}, {31'd0, sub_sra}, {31'd0, e.sub_sra});
    check({tag, ".funct3"},  {29'd0, alu_funct3}, {29'd0, e.f3});
    check({tag, ".imm"},     imm, e.imm);
    check({tag, ".shamt"},   {27'd0, shamt}, {27'd0, e.shamt});
    check({tag, ".rd"},      {27'd0, rd}, {27'd0, e.rd});
    check({tag, ".rs1"},     {27'd0, rs1}, {27'd0, e.rs1});
    check({tag, ".reg_we"},  {31'd0, reg_we}, {31'd0, e.reg_we});
    check({tag, ".valid"},   {31'd0, valid}, {31'd0, e.valid});
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      compare_all(tag, e);
    end
  endtask

  task automatic drive(input string tag, input logic [31:0] w);
    @(negedge clk);
    insn = w;
    sb_q.push_back(model(w));
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  initial begin
    exp_t zero_e;
    logic [31:0] v;
    zero_e  = '0;
    reset_n = 1'b1;
    insn    = 32'h0;
    #0.5;
    reset_n = 1'b0;
    insn    = 32'h4027DA13;
    #1;
    compare_all("rst", zero_e);
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all("rst_hold", zero_e);

    // First edge after release decodes the SRAI already on the bus.
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.push_back(model(insn));
    @(posedge clk);
    #1;
    pop_compare("post_rst");
    check("post_rst.sub_sra_const", {31'd0, sub_sra}, 32'd1);

    drive("addi", 32'h00A10093);
    check("addi.imm_const", imm, 32'h0000000A);
    check("addi.reg_we_const", {31'd0, reg_we}, 32'd1);
    drive("srai", 32'h4027DA13);
    check("srai.rd_const", {27'd0, rd}, 32'd20);
    check("srai.rs1_const", {27'd0, rs1}, 32'd15);
    drive("srli", 32'h0027DA13);
    drive("addi_b30", 32'h40010093);
    check("addi_b30.sub_sra_const", {31'd0, sub_sra}, 32'd0);
    check("addi_b30.imm_const", imm, 32'h00000400);
    drive("bad_f7", 32'h2027DA13);
    check("bad_f7.valid_const", {31'd0, valid}, 32'd0);
    drive("rtype", 32'h4027DA33);
    drive("slli_ok", 32'h00209093);
    drive("slli_bad", 32'h40209093);
    drive("xori_neg", 32'h80014193);
    drive("addi_x0", 32'hFFF00013);
    check("addi_x0.imm_const", imm, 32'hFFFFFFFF);
    check("addi_x0.reg_we_const", {31'd0, reg_we}, 32'd0);

    // Mid-stream reset between edges clears outputs asynchronously.
    #0.5;
    reset_n = 1'b0;
    #0.5;
    compare_all("mid_rst", zero_e);
    @(negedge clk);
    reset_n = 1'b1;
    drive("resume", 32'h4027DA13);

    for (int i = 0; i < 24; i++) begin
      v = $urandom;
      if (i % 2 == 1) v[6:0] = 7'b0010011;
      if (i % 4 == 1) begin
        v[14:12] = 3'b101;
        case (i % 3)
          0:       v[31:25] = 7'b0100000;
          1:       v[31:25] = 7'b0000000;
          default: v[31:25] = v[31:25];
        endcase
      end
      drive("rand", v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decoder_i_insn_alu.md
Name: decoder_i_insn_alu

Overview:
- Decoder for RV32I OP-IMM instructions (opcode 7'b0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI).
- Sits in the Control Unit's per-format decoder set.
- Turns a 32-bit instruction word into registered ALU control fields, chiefly `sub_sra`, which selects arithmetic right shift in the ALU.
- All outputs are registered on the processor clock.

Parameters:
- XLEN, 32, data/immediate width; only 32 is supported.

Ports:
- clk  input  1  system clock; all outputs update on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- insn  input  32  instruction word; RISC-V bit numbering.
- sub_sra  output  1  1 = ALU performs SRA (valid SRAI); 0 otherwise.
- alu_funct3  output  3  insn[14:12] for the ALU operation select.
- imm  output  32  insn[31:20] sign-extended to 32 bits.
- shamt  output  5  insn[24:20].
- rd  output  5  insn[11:7].
- rs1  output  5  insn[19:15].
- reg_we  output  1  destination write enable.
- valid  output  1  insn is a legal OP-IMM encoding.

Behaviour:
- Reset: reset_n low clears every output to 0 immediately, independent of clk. Outputs are held at 0 while reset_n is low.
- Latency: outputs reflect the insn sampled at the most recent rising clk edge; one-cycle latency. insn must be stable around the edge.
- is_opimm = (insn[6:0] == 7'b0010011).
- Shift legality:
  - funct3 = 001 is legal only when insn[31:25] = 0000000.
  - funct3 = 101 is legal only when insn[31:25] is 0000000 or 0100000.
  - All other funct3 values are legal for any insn[31:25].
- valid = is_opimm & shift-legal.
- sub_sra = valid & (funct3 == 101) & insn[30].
  - ADDI never asserts sub_sra: there is no SUBI, so insn[30] is ignored for funct3 = 000.
  - sub_sra is 0 for SRLI, all non-shift ops, illegal encodings, and non-OP-IMM opcodes.
- reg_we = valid & (rd != 0).
- When valid = 0:
  - alu_funct3, imm, shamt, rd and rs1 still carry the raw decoded fields.
  - sub_sra and reg_we are forced to 0.
- imm is always the sign extension of insn[31:20]. Example: for SRAI the raw value 0x402 gives imm = 32'h00000402.
- No internal state besides the output register. A reset asserted mid-stream takes effect immediately; decoding resumes at the first rising edge after reset_n rises.

Decomposition:
- Shared package (rv32i_pkg):
  - OPCODE_OP_IMM = 7'b0010011.
  - funct3 constants: F3_ADD = 000, F3_SLL = 001, F3_SLT = 010, F3_SLTU = 011, F3_XOR = 100, F3_SRL_SRA = 101, F3_OR = 110, F3_AND = 111.
  - FUNCT7_ALT = 7'b0100000.
- One sub-module: rv_field_extract, a combinational slicer for opcode, rd, rs1, funct3, funct7 and imm_i. It is reused by the other format decoders.
- The clock source for benches is the shared clock_gen model:
  - 50% duty, 4 ns period.
  - Starts low, first rising edge at 2 ns.

Test Plan:
- reset_n = 0, insn = 32'h4027DA13 -> all outputs 0; then release reset_n and clock -> sub_sra = 1.
- insn = 32'h00A10093 (addi x1,x2,10), wait 10 ns -> sub_sra = 0, valid = 1, alu_funct3 = 000, imm = 32'h0000000A, rd = 1, rs1 = 2, reg_we = 1.
- insn = 32'h4027DA13 (srai x20,x15,2), wait 10 ns -> sub_sra = 1, valid = 1, alu_funct3 = 101, shamt = 2, rd = 20, rs1 = 15.
- insn = 32'h0027DA13 (srli) -> sub_sra = 0, valid = 1; insn = 32'h40010093 (addi with bit30 set, imm 0x400) -> sub_sra = 0, imm = 32'h00000400.
- insn = 32'h2027DA13 (illegal funct7 on shift) -> valid = 0, sub_sra = 0, reg_we = 0. insn = 32'h4027DA33 (R-type SRA, wrong opcode) -> valid = 0, sub_sra = 0.
- insn = 32'hFFF00013 (addi x0,x0,-1) -> imm = 32'hFFFFFFFF, reg_we = 0. Assert reset_n low between clock edges -> outputs drop to 0 before the next edge.
